// File: rtl/ext_bus_ctrl_if.sv
// Requester handshakes plus external multiplexed bus pins for ext_bus_ctrl.
// master: the CPU/debug requesters together with the external device;
// slave: the controller.
interface ext_bus_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_space;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;

  logic        dbg_req;
  logic        dbg_we;
  logic [1:0]  dbg_space;
  logic [15:0] dbg_addr;
  logic [7:0]  dbg_wdata;
  logic        dbg_ack;
  logic [7:0]  dbg_rdata;

  logic [7:0]  bus_in;
  logic [7:0]  bus_out;
  logic        bus_oe;
  logic        le_lo;
  logic        le_hi;
  logic        oe_n;
  logic        we_n;
  logic        iod;
  logic        ioc;

  modport master (
    output cpu_req, cpu_we, cpu_space, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output dbg_req, dbg_we, dbg_space, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata,
    output bus_in,
    input  bus_out, bus_oe, le_lo, le_hi, oe_n, we_n, iod, ioc
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_space, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  dbg_req, dbg_we, dbg_space, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata,
    input  bus_in,
    output bus_out, bus_oe, le_lo, le_hi, oe_n, we_n, iod, ioc
  );
endinterface

// File: rtl/ext_bus_ctrl.sv
// Sequencer and two-port arbiter for the AS2650 multiplexed 8-bit external bus.
// Each transfer runs ALO -> (AHI) -> ACC x (WAIT_STATES+1) -> DONE; the address
// high byte is cached so AHI is skipped while the page is unchanged.
// All bus outputs are registered: they are loaded on the edge entering a phase.
module ext_bus_ctrl #(
  parameter int WAIT_STATES = 1
) (
  input logic clk,
  input logic rst_n,
  ext_bus_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ALO, AHI, ACC, DONE} state_t;

  localparam logic [2:0] LAST_CNT = 3'(WAIT_STATES);

  state_t      state;
  logic        owner;
  logic        last;
  logic        req_we;
  logic [1:0]  req_space;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic [7:0]  hi_shadow;
  logic        hi_valid;
  logic [2:0]  cnt;

  logic        any_req;
  logic        grant_dbg;
  logic [15:0] sel_addr;
  logic        need_hi;
  logic        enter_acc;
  logic        acc_oe_n;
  logic        acc_we_n;
  logic        acc_bus_oe;
  logic [7:0]  acc_bus_out;
  logic        acc_iod;
  logic        acc_ioc;

  // Arbitration, page-cache lookup and the strobe pattern of the access phase
  always_comb begin
    any_req   = bus.cpu_req | bus.dbg_req;
    grant_dbg = bus.dbg_req;
    if (bus.cpu_req && bus.dbg_req) grant_dbg = ~last;
    sel_addr  = grant_dbg ? bus.dbg_addr : bus.cpu_addr;
    need_hi   = !hi_valid || (req_addr[15:8] != hi_shadow);
    enter_acc = ((state == ALO) && !need_hi) || (state == AHI) ||
                ((state == ACC) && (cnt != LAST_CNT));
    acc_oe_n    = req_we;
    acc_we_n    = ~req_we;
    acc_bus_oe  = req_we;
    acc_bus_out = req_we ? req_wdata : 8'h00;
    acc_iod     = (req_space == 2'd1);
    acc_ioc     = (req_space == 2'd2);
  end

  // Transfer sequencer with registered bus strobes, acks and read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner         <= 1'b0;
      last          <= 1'b1;
      req_we        <= 1'b0;
      req_space     <= 2'd0;
      req_addr      <= 16'h0000;
      req_wdata     <= 8'h00;
      hi_shadow     <= 8'h00;
      hi_valid      <= 1'b0;
      cnt           <= 3'd0;
      bus.le_lo     <= 1'b0;
      bus.le_hi     <= 1'b0;
      bus.oe_n      <= 1'b1;
      bus.we_n      <= 1'b1;
      bus.iod       <= 1'b0;
      bus.ioc       <= 1'b0;
      bus.bus_oe    <= 1'b0;
      bus.bus_out   <= 8'h00;
      bus.cpu_ack   <= 1'b0;
      bus.dbg_ack   <= 1'b0;
      bus.cpu_rdata <= 8'h00;
      bus.dbg_rdata <= 8'h00;
    end else begin
      bus.le_lo   <= 1'b0;
      bus.le_hi   <= 1'b0;
      bus.oe_n    <= 1'b1;
      bus.we_n    <= 1'b1;
      bus.iod     <= 1'b0;
      bus.ioc     <= 1'b0;
      bus.bus_oe  <= 1'b0;
      bus.bus_out <= 8'h00;
      bus.cpu_ack <= 1'b0;
      bus.dbg_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner       <= grant_dbg;
            req_we      <= grant_dbg ? bus.dbg_we    : bus.cpu_we;
            req_space   <= grant_dbg ? bus.dbg_space : bus.cpu_space;
            req_wdata   <= grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
            req_addr    <= sel_addr;
            state       <= ALO;
            bus.le_lo   <= 1'b1;
            bus.bus_oe  <= 1'b1;
            bus.bus_out <= sel_addr[7:0];
          end
        end
        ALO: begin
          cnt <= 3'd0;
          if (need_hi) begin
            state       <= AHI;
            bus.le_hi   <= 1'b1;
            bus.bus_oe  <= 1'b1;
            bus.bus_out <= req_addr[15:8];
          end else begin
            state <= ACC;
          end
        end
        AHI: begin
          hi_shadow <= req_addr[15:8];
          hi_valid  <= 1'b1;
          cnt       <= 3'd0;
          state     <= ACC;
        end
        ACC: begin
          if (cnt == LAST_CNT) begin
            state <= DONE;
            if (owner) begin
              bus.dbg_ack <= 1'b1;
              if (!req_we) bus.dbg_rdata <= bus.bus_in;
            end else begin
              bus.cpu_ack <= 1'b1;
              if (!req_we) bus.cpu_rdata <= bus.bus_in;
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: begin
          last  <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (enter_acc) begin
        bus.oe_n    <= acc_oe_n;
        bus.we_n    <= acc_we_n;
        bus.bus_oe  <= acc_bus_oe;
        bus.bus_out <= acc_bus_out;
        bus.iod     <= acc_iod;
        bus.ioc     <= acc_ioc;
      end
    end
  end
endmodule

// File: doc/ext_bus_ctrl.md
# ext_bus_ctrl

Sequencer and two-port arbiter for the AS2650 multiplexed external 8-bit bus. Shares one external bus between the CPU core and the Wishbone debug bridge. For each transfer it drives the address low/high latch enables, then a read or write strobe with optional I/O-space qualifiers. The address high byte is cached so the LE_HI phase is skipped when that byte is unchanged. It sits between the core/debug ports and the io_out/io_in/io_oeb pad mapping.

## Interface

**Parameters**
- WAIT_STATES, default 1: extra strobe cycles beyond the minimum of one; legal range 0..7.

**Ports**
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU request; held until cpu_ack.
- cpu_we  in  1  1 = write.
- cpu_space  in  2  0 = memory, 1 = IOD, 2 = IOC, 3 = treated as memory.
- cpu_addr  in  16  byte address.
- cpu_wdata  in  8  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  read data; valid while cpu_ack is high, held until the next CPU read completes.
- dbg_req, dbg_we, dbg_space, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata: same as the cpu_* ports, for the debug requester.
- bus_in  in  8  external bus read value.
- bus_out  out  8  external bus drive value.
- bus_oe  out  1  1 = pads drive bus_out (maps to inverted io_oeb).
- le_lo  out  1  address low latch enable, active high.
- le_hi  out  1  address high latch enable, active high.
- oe_n  out  1  read strobe, active low.
- we_n  out  1  write strobe, active low.
- iod  out  1  data I/O space qualifier.
- ioc  out  1  control I/O space qualifier.

## Operation

**States:** IDLE, ALO, AHI, ACC, DONE.

**IDLE**
- Requests are sampled only in IDLE.
- If exactly one requester is pending, grant it.
- If both are pending, grant the one not granted last. The `last` bit resets to "dbg", so the CPU wins the first tie.
- On grant, register we, space, addr and wdata, plus the owner. Go to ALO.

**ALO** (1 cycle)
- bus_out = addr[7:0], bus_oe = 1, le_lo = 1.
- Next state: AHI if hi_valid = 0 or addr[15:8] != hi_shadow; otherwise ACC.

**AHI** (1 cycle)
- bus_out = addr[15:8], bus_oe = 1, le_hi = 1.
- hi_shadow <= addr[15:8]; hi_valid <= 1.

**ACC** (WAIT_STATES+1 cycles, counted by a 3-bit counter)
- Read: oe_n = 0, bus_oe = 0.
- Write: we_n = 0, bus_oe = 1, bus_out = wdata.
- iod = 1 when space = 1; ioc = 1 when space = 2. Both stay 0 for memory.
- On a read, bus_in is captured into the owner's rdata register at the final ACC edge.

**DONE** (1 cycle)
- All strobes are inactive, bus_oe = 0.
- The owner's ack = 1; `last` <= owner.
- Next state: IDLE.

**Outputs outside the active phases**
- le_lo = le_hi = 0, oe_n = we_n = 1, iod = ioc = 0, bus_oe = 0, bus_out = 0.

**Mutual exclusion**
- At most one of le_lo, le_hi, (oe_n == 0), (we_n == 0) is active in any cycle.

## Timing

**Reset** (asynchronous, immediate, including mid-transfer):
- State = IDLE.
- le_lo = le_hi = 0, oe_n = we_n = 1, iod = ioc = 0, bus_oe = 0, bus_out = 0.
- cpu_ack = dbg_ack = 0; cpu_rdata = dbg_rdata = 0.
- hi_valid = 0, hi_shadow = 0, `last` = dbg.
- A transfer interrupted by reset is abandoned without ack. The requester re-issues it after reset.

**Latency** (grant edge = the IDLE edge that takes the request):
- ack is high in cycle 3 + WAIT_STATES after the grant edge when the AHI phase is skipped.
- ack is high in cycle 4 + WAIT_STATES after the grant edge when the AHI phase is taken.
- With WAIT_STATES = 1 and AHI taken, ack is high in cycle 5.

**Throughput**
- Each transfer includes one IDLE cycle after DONE.
- Back-to-back same-page reads with WAIT_STATES = 1 complete every 5 cycles.

**Request handling**
- A req that drops before ack is still completed. The ack pulse is delivered regardless.
- Request inputs are ignored outside IDLE. A request arriving mid-transfer waits.

**High-byte cache**
- The cache is shared across requesters and spaces, because the external latch is shared.
- A high-byte match after wrap-around (e.g. 0x12FF then 0x1200) still skips AHI.

## Test plan

1. **Reset mid-transfer:** reset asserted during ACC of a write -> we_n returns to 1 and bus_oe to 0 in the same cycle, no ack. The next request to 0x3400 takes the AHI phase (hi_valid cleared).
2. **First read:** after reset, CPU reads 0x1234, memory holds 0xA5, WAIT_STATES = 1 -> le_lo with bus_out = 0x34, then le_hi with bus_out = 0x12, then oe_n low for 2 cycles. cpu_ack in cycle 5, cpu_rdata = 0xA5.
3. **Same-page skip:** CPU write 0x5A to 0x1240 after test 2 -> no le_hi pulse, we_n low 2 cycles with bus_out = 0x5A, ack in cycle 4. Memory[0x1240] = 0x5A.
4. **Arbitration:** CPU and debug both requesting continuously -> grants alternate CPU, dbg, CPU, dbg. Each ack goes only to its owner and acks never overlap.
5. **I/O spaces:** dbg write 0x77 to space IOC at 0x0010, then CPU read in space IOD -> ioc = 1 only during the write strobe, iod = 1 only during the read strobe. Neither is ever asserted during le_lo or le_hi.
6. **WAIT_STATES = 0 with page change:** read 0x00FF, then read 0x0100 -> the second read takes AHI with bus_out = 0x01. oe_n is low for exactly 1 cycle per read.
